// File: rtl/seq_alu.sv
// seq_alu - sequential ALU with iterative multiplier and optional divider.
//
// Ports:
//   clk        sole clock, all state changes on the rising edge
//   rst_n      synchronous active-low reset
//   in_valid   request strobe; a transfer happens on in_valid && in_ready
//   in_ready   block can take a request this cycle
//   op[4:0]    op[4]=0: ALU code in op[3:0]
//              op[4]=1: op[1:0] 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a, b       operands (WIDTH bits)
//   out_valid  result is held on hi/lo
//   out_ready  consumer takes the result
//   hi, lo     result: lo = ALU result / product low / quotient,
//              hi = 0 / product high / remainder
//
// ALU codes (op[3:0]): 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLTU,
//   7 SLL, 8 SRL, 9 SRA, 10 COPY_B; 11..15 return hi = lo = 0.
//
// Configuration: define SEQ_ALU_DIV_EN to build the restoring divider.
//   Without it DIV/DIVU complete in one cycle with hi = lo = 0.
module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int SHW  = $clog2(WIDTH);
  localparam int LAST = WIDTH - 1;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;
  localparam logic [3:0] ALU_CPB  = 4'd10;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e             state_q, state_d;
  logic [SHW:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0]   mcand_q;
  logic               negRes_q;
  logic               accept, longOp, isLast;
  logic [SHW-1:0]     shamt;
  logic [WIDTH-1:0]   aluRes, shortLo, aMag, bMag;
  logic               aNeg, bNeg;
  logic [WIDTH:0]     mulSum;
  logic [WIDTH-1:0]   mulHi, mulLo;
  logic [2*WIDTH-1:0] mulFix;

  // Requests that need the iterative datapath; a disabled divider turns
  // DIV/DIVU into single-cycle zero-result ops.
`ifdef SEQ_ALU_DIV_EN
  assign longOp = op[4];
`else
  assign longOp = op[4] & ~op[1];
`endif

  assign accept = in_valid && in_ready;
  assign isLast = (cnt_q == LAST[SHW:0]);
  assign shamt  = b[SHW-1:0];

  // Signed MULT/DIV run on magnitudes; op[0]=0 marks the signed variants.
  assign aNeg = ~op[0] & a[WIDTH-1];
  assign bNeg = ~op[0] & b[WIDTH-1];
  assign aMag = aNeg ? -a : a;
  assign bMag = bNeg ? -b : b;

  // Single-cycle ALU function, all results modulo 2^WIDTH.
  always_comb begin
    aluRes = '0;
    case (op[3:0])
      ALU_ADD:  aluRes = a + b;
      ALU_SUB:  aluRes = a - b;
      ALU_AND:  aluRes = a & b;
      ALU_OR:   aluRes = a | b;
      ALU_XOR:  aluRes = a ^ b;
      ALU_SLT:  aluRes[0] = $signed(a) < $signed(b);
      ALU_SLTU: aluRes[0] = a < b;
      ALU_SLL:  aluRes = a << shamt;
      ALU_SRL:  aluRes = a >> shamt;
      ALU_SRA:  aluRes = $signed(a) >>> shamt;
      ALU_CPB:  aluRes = b;
      default:  aluRes = '0;
    endcase
  end

  assign shortLo = op[4] ? '0 : aluRes;

  // One shift-add step: hi accumulates, lo holds the multiplier and
  // collects product bits from the top as it shifts right.
  assign mulSum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
  assign mulHi  = mulSum[WIDTH:1];
  assign mulLo  = {mulSum[0], lo_q[WIDTH-1:1]};
  assign mulFix = negRes_q ? -{mulHi, mulLo} : {mulHi, mulLo};

`ifdef SEQ_ALU_DIV_EN
  logic             isDiv_q, negRem_q;
  logic [WIDTH-1:0] aSave_q;
  logic [WIDTH:0]   divShift, divTrial;
  logic [WIDTH-1:0] divRem, divQuo;

  // One restoring step: hi is the partial remainder, lo shifts the dividend
  // out at the top and the quotient bits in at the bottom.
  always_comb begin
    divShift = {hi_q, lo_q[WIDTH-1]};
    divTrial = divShift - {1'b0, mcand_q};
    if (!divTrial[WIDTH]) begin
      divRem = divTrial[WIDTH-1:0];
      divQuo = {lo_q[WIDTH-2:0], 1'b1};
    end else begin
      divRem = divShift[WIDTH-1:0];
      divQuo = {lo_q[WIDTH-2:0], 1'b0};
    end
  end
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state; DONE with out_ready behaves like IDLE so results can
  // stream back to back.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (in_valid) state_d = longOp ? BUSY : DONE;
      BUSY: if (isLast) state_d = DONE;
      DONE: begin
        if (out_ready) state_d = in_valid ? (longOp ? BUSY : DONE) : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs.
  always_comb begin
    in_ready  = (state_q == IDLE) || (state_q == DONE && out_ready);
    out_valid = (state_q == DONE);
    hi        = hi_q;
    lo        = lo_q;
  end

  // Result/working registers: loaded on accept, stepped while BUSY, with the
  // sign fix-up folded into the last step.
  always_comb begin
    hi_d  = hi_q;
    lo_d  = lo_q;
    cnt_d = cnt_q;
    if (accept) begin
      cnt_d = '0;
      hi_d  = '0;
      lo_d  = longOp ? aMag : shortLo;
    end else if (state_q == BUSY) begin
      cnt_d        = cnt_q + 1'b1;
      {hi_d, lo_d} = isLast ? mulFix : {mulHi, mulLo};
`ifdef SEQ_ALU_DIV_EN
      if (isDiv_q) begin
        if (!isLast) begin
          hi_d = divRem;
          lo_d = divQuo;
        end else if (mcand_q == '0) begin
          hi_d = aSave_q;
          lo_d = '1;
        end else begin
          hi_d = negRem_q ? -divRem : divRem;
          lo_d = negRes_q ? -divQuo : divQuo;
        end
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hi_q  <= '0;
      lo_q  <= '0;
      cnt_q <= '0;
    end else begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      cnt_q <= cnt_d;
    end
  end

  // Operand side information kept for the whole iterative operation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      negRes_q <= 1'b0;
`ifdef SEQ_ALU_DIV_EN
      isDiv_q  <= 1'b0;
      negRem_q <= 1'b0;
      aSave_q  <= '0;
`endif
    end else if (accept && longOp) begin
      mcand_q  <= bMag;
      negRes_q <= aNeg ^ bNeg;
`ifdef SEQ_ALU_DIV_EN
      isDiv_q  <= op[1];
      negRem_q <= aNeg;
      aSave_q  <= a;
`endif
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Testbench for seq_alu (WIDTH=32): constant vector table, randomized ops
// against a plain-arithmetic reference model, and hand-written sequences for
// backpressure and reset during a multiply.
module tb_seq_alu;

  localparam int WIDTH = 32;
`ifdef SEQ_ALU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  localparam logic [4:0] OP_ADD = 5'h00, OP_SUB = 5'h01, OP_AND = 5'h02,
                         OP_OR = 5'h03, OP_XOR = 5'h04, OP_SLT = 5'h05,
                         OP_SLTU = 5'h06, OP_SLL = 5'h07, OP_SRL = 5'h08,
                         OP_SRA = 5'h09, OP_CPB = 5'h0A, OP_BAD = 5'h0F,
                         OP_MULT = 5'h10, OP_MULTU = 5'h11,
                         OP_DIV = 5'h12, OP_DIVU = 5'h13;

  logic clk = 1'b0;
  logic rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [4:0] op;
  logic [WIDTH-1:0] a, b, hi, lo;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .hi(hi), .lo(lo)
  );

  typedef struct {
    string      name;
    logic [4:0] op;
    logic [31:0] a, b, expHi, expLo;
    int         expLat;
  } vec_t;

  // Reference result {hi, lo} from the arithmetic definition of each op.
  function automatic logic [63:0] refModel(input logic [4:0] o, input logic [31:0] x, y);
    longint sx, sy;
    logic [63:0] res;
    sx  = longint'($signed(x));
    sy  = longint'($signed(y));
    res = '0;
    if (!o[4]) begin
      case (o[3:0])
        4'd0:  res[31:0] = x + y;
        4'd1:  res[31:0] = x - y;
        4'd2:  res[31:0] = x & y;
        4'd3:  res[31:0] = x | y;
        4'd4:  res[31:0] = x ^ y;
        4'd5:  res[0] = (sx < sy);
        4'd6:  res[0] = (x < y);
        4'd7:  res[31:0] = x << y[4:0];
        4'd8:  res[31:0] = x >> y[4:0];
        4'd9:  res[31:0] = 32'(sx >>> y[4:0]);
        4'd10: res[31:0] = y;
        default: res = '0;
      endcase
    end else begin
      case (o[1:0])
        2'd0: res = sx * sy;
        2'd1: res = {32'h0, x} * {32'h0, y};
        2'd2: begin
          if (!DIV_EN) res = '0;
          else if (y == 0) res = {x, 32'hFFFF_FFFF};
          else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) res = {32'h0, 32'h8000_0000};
          else res = {32'(sx % sy), 32'(sx / sy)};
        end
        default: begin
          if (!DIV_EN) res = '0;
          else if (y == 0) res = {x, 32'hFFFF_FFFF};
          else res = {x % y, x / y};
        end
      endcase
    end
    return res;
  endfunction

  function automatic int refLatency(input logic [4:0] o);
    return (o[4] && (DIV_EN || !o[1])) ? WIDTH + 1 : 1;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Offer one op, measure cycles from the accepting edge to out_valid,
  // capture the result and consume it.
  task automatic applyStimulus(input logic [4:0] o, input logic [31:0] x, y,
                               output logic [31:0] hiV, loV, output int lat);
    int guard;
    @(negedge clk);
    op = o; a = x; b = y; in_valid = 1'b1; out_ready = 1'b0;
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    hiV = hi; loV = lo;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t vecs[$];
    logic [31:0] gotHi, gotLo, holdHi, holdLo;
    logic [63:0] exp;
    logic [4:0] ro;
    logic [31:0] ra, rb;
    int lat, k, readyInBusy, staleCount;

    vecs.push_back('{"add_wrap", OP_ADD, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h0, 1});
    vecs.push_back('{"sra", OP_SRA, 32'h8000_0000, 32'h24, 32'h0, 32'hF800_0000, 1});
    vecs.push_back('{"sub", OP_SUB, 32'd5, 32'd7, 32'h0, 32'hFFFF_FFFE, 1});
    vecs.push_back('{"and", OP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0, 32'hF000_F000, 1});
    vecs.push_back('{"or", OP_OR, 32'h0F0F_0000, 32'h0000_00F0, 32'h0, 32'h0F0F_00F0, 1});
    vecs.push_back('{"xor", OP_XOR, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'h0, 32'hF0F0_0F0F, 1});
    vecs.push_back('{"slt", OP_SLT, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h1, 1});
    vecs.push_back('{"sltu", OP_SLTU, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h0, 1});
    vecs.push_back('{"sll", OP_SLL, 32'h1, 32'h3F, 32'h0, 32'h8000_0000, 1});
    vecs.push_back('{"srl", OP_SRL, 32'h8000_0000, 32'h4, 32'h0, 32'h0800_0000, 1});
    vecs.push_back('{"copyb", OP_CPB, 32'h0, 32'h1234_5678, 32'h0, 32'h1234_5678, 1});
    vecs.push_back('{"badop", OP_BAD, 32'h1, 32'h1, 32'h0, 32'h0, 1});
    vecs.push_back('{"mult", OP_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 33});
    vecs.push_back('{"multu", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 33});
`ifdef SEQ_ALU_DIV_EN
    vecs.push_back('{"div", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33});
    vecs.push_back('{"div_negb", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'h1, 32'hFFFF_FFFD, 33});
    vecs.push_back('{"divu_zero", OP_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 33});
    vecs.push_back('{"div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 33});
`else
    vecs.push_back('{"divu_off", OP_DIVU, 32'd9, 32'd3, 32'h0, 32'h0, 1});
    vecs.push_back('{"div_off", OP_DIV, 32'd7, 32'd2, 32'h0, 32'h0, 1});
`endif

    // Reset state.
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_hi", hi, 0);
    checkOutput("rst_lo", lo, 0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_in_ready", in_ready, 1);

    // Constant vector table.
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, gotHi, gotLo, lat);
      checkOutput({vecs[i].name, "_hi"}, gotHi, vecs[i].expHi);
      checkOutput({vecs[i].name, "_lo"}, gotLo, vecs[i].expLo);
      checkOutput({vecs[i].name, "_lat"}, lat, vecs[i].expLat);
    end

    // Randomized ops against the reference model.
    for (int i = 0; i < 60; i++) begin
      k = $urandom_range(0, 15);
      if (k < 11)      ro = 5'(k);
      else if (k < 15) ro = 5'h10 + 5'(k - 11);
      else             ro = 5'h0C;
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      applyStimulus(ro, ra, rb, gotHi, gotLo, lat);
      exp = refModel(ro, ra, rb);
      checkOutput($sformatf("rand%0d_op%0h_hi", i, ro), gotHi, exp[63:32]);
      checkOutput($sformatf("rand%0d_op%0h_lo", i, ro), gotLo, exp[31:0]);
      checkOutput($sformatf("rand%0d_op%0h_lat", i, ro), lat, refLatency(ro));
    end

    // Backpressure: junk requests while BUSY are ignored, result held while
    // out_ready is low, then a new ADD is accepted on the handoff edge.
    @(negedge clk);
    op = OP_MULT; a = 32'd6; b = 32'hFFFF_FFF9; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    op = OP_ADD; a = 32'd1; b = 32'd1;
    readyInBusy = 0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      if (in_ready) readyInBusy++;
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    checkOutput("bp_lat", lat, 33);
    checkOutput("bp_busy_ready", readyInBusy, 0);
    checkOutput("bp_hi", hi, 32'hFFFF_FFFF);
    checkOutput("bp_lo", lo, 32'hFFFF_FFD6);
    holdHi = hi; holdLo = lo;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("bp_hold_valid", out_valid, 1);
      checkOutput("bp_hold_ready", in_ready, 0);
      checkOutput("bp_hold_hi", hi, holdHi);
      checkOutput("bp_hold_lo", lo, holdLo);
    end
    out_ready = 1'b1; in_valid = 1'b1; op = OP_ADD; a = 32'd2; b = 32'd3;
    #1;
    checkOutput("bp_handoff_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("bp_next_valid", out_valid, 1);
    checkOutput("bp_next_lo", lo, 32'd5);
    checkOutput("bp_next_hi", hi, 32'd0);
    @(negedge clk);
    checkOutput("bp_drained_valid", out_valid, 0);
    out_ready = 1'b0;

    // Reset on the 5th BUSY cycle of a MULTU abandons it.
    @(negedge clk);
    op = OP_MULTU; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("mid_busy_ready", in_ready, 0);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("midrst_valid", out_valid, 0);
    checkOutput("midrst_hi", hi, 0);
    checkOutput("midrst_lo", lo, 0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("midrst_in_ready", in_ready, 1);
    staleCount = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) staleCount++;
    end
    checkOutput("midrst_stale", staleCount, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits (legal: 8..64, power of two).
REQ-002 SHALL derive localparam SHW = $clog2(WIDTH), the shift-amount width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  operation request.
REQ-006 SHALL have port in_ready  output  1  block can accept a request this cycle.
REQ-007 SHALL have port op  input  5  op[4]=0: op[3:0] is the standard ALUop code; op[4]=1: op[1:0] = 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-008 SHALL have ports a, b  input  WIDTH  operands.
REQ-009 SHALL have port out_valid  output  1  result available.
REQ-010 SHALL have port out_ready  input  1  consumer takes the result.
REQ-011 SHALL have ports hi, lo  output  WIDTH  result; lo = ALU result or product low/quotient, hi = product high/remainder.

Function
REQ-012 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-013 SHALL transfer a request only when in_valid && in_ready; SHALL capture op, a and b on that edge.
REQ-014 SHALL drive in_ready = (state==IDLE) || (state==DONE && out_ready), giving back-to-back acceptance on result handoff.
REQ-015 SHALL, for op[4]=0, go IDLE->DONE with lo = ALU function, hi = 0; out_valid asserts on the cycle after acceptance (latency 1).
REQ-016 SHALL support ADD, SUB, AND, OR, XOR, SLT (signed), SLTU, SLL, SRL, SRA, COPY_B, modulo 2^WIDTH; shifts use b[SHW-1:0]; unknown codes give lo = hi = 0.
REQ-017 SHALL, for MULT/MULTU, go IDLE->BUSY, iterate one radix-2 shift-add step per cycle for exactly WIDTH cycles, then DONE; {hi,lo} = 2*WIDTH-bit product.
REQ-018 SHALL compute signed MULT/DIV on magnitudes and apply sign fix-up in the final BUSY cycle without an extra cycle.
REQ-019 SHALL, for DIV/DIVU, perform restoring division one quotient bit per cycle for exactly WIDTH BUSY cycles; remainder sign follows dividend.
REQ-020 SHALL, on divide by zero, return lo = all ones, hi = a, same latency.
REQ-021 SHALL, on signed DIV of most-negative by -1, return lo = most-negative, hi = 0.
REQ-022 SHALL hold hi, lo and out_valid stable in DONE until out_ready; DONE->IDLE on out_ready when no new request is accepted.
REQ-023 SHALL deassert out_valid on the edge consuming the result unless a new 1-cycle op is accepted that same edge, in which case out_valid stays high with new data.
REQ-024 SHALL ignore in_valid, op, a and b while BUSY; an iteration counter of SHW+1 bits SHALL end BUSY at count WIDTH-1.

Reset
REQ-025 SHALL, when rst_n is low at a clock edge, enter IDLE, clear the counter and drive out_valid = 0, hi = 0, lo = 0; in_ready = 1 the cycle after reset releases.
REQ-026 SHALL abandon any in-flight BUSY or DONE operation on reset with no result emitted.

Configuration
REQ-027 SHALL compile the divider only when macro SEQ_ALU_DIV_EN is defined.
REQ-028 SHALL, without SEQ_ALU_DIV_EN, accept DIV/DIVU as 1-cycle ops returning hi = lo = 0; MULT/MULTU and ALU ops unchanged.

Verification (WIDTH=32, SEQ_ALU_DIV_EN defined unless noted)
REQ-029 SHALL test ADD a=0xFFFFFFFF, b=1, out_ready=1 -> out_valid next cycle, lo=0, hi=0; SRA a=0x80000000, b=0x24 -> lo=0xF8000000.
REQ-030 SHALL test MULT a=-3, b=7 -> out_valid 33 cycles after acceptance, hi=0xFFFFFFFF, lo=0xFFFFFFEB; MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-031 SHALL test DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU a=5, b=0 -> lo=0xFFFFFFFF, hi=5; DIV 0x80000000 by -1 -> lo=0x80000000, hi=0.
REQ-032 SHALL test backpressure: out_ready=0 for 10 cycles after DONE -> hi/lo/out_valid stable, in_ready=0; new ADD offered when out_ready rises -> accepted that edge, out_valid stays high.
REQ-033 SHALL test rst_n low on 5th BUSY cycle of MULTU -> next cycle out_valid=0, hi=lo=0, in_ready=1 after release, no stale result.
REQ-034 SHALL test build without SEQ_ALU_DIV_EN: DIVU a=9, b=3 -> out_valid next cycle, hi=lo=0.
